// File: rtl/reaction_sequencer.sv
// Reaction timer game controller: IDLE -> PREP -> TEST -> RESULT with a FALSE_START penalty branch.
// Single cycle: every output is registered and updates on the edge after the qualifying input cycle.
module reaction_sequencer #(
    parameter int MAX_REACT_MS  = 9999,
    parameter int FALSE_HOLD_MS = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rising_edge_1khz,
    input  logic        button_press,
    input  logic        clear_best,
    input  logic        timeout,
    output logic [2:0]  current_state,
    output logic [13:0] reaction_ms,
    output logic [13:0] best_ms,
    output logic        new_best,
    output logic        no_response,
    output logic        go_led
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PREP   = 3'd1;
    localparam logic [2:0] S_TEST   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_FALSE  = 3'd4;

    localparam logic [13:0] MAX_C  = 14'(MAX_REACT_MS);
    localparam logic [13:0] HOLD_C = 14'(FALSE_HOLD_MS);

    logic [2:0]  state_q, state_d;
    logic [13:0] cnt_q, cnt_d;
    logic [13:0] reaction_q, reaction_d;
    logic [13:0] best_q, best_d;
    logic        new_best_q, new_best_d;
    logic        no_resp_q, no_resp_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            reaction_q <= '0;
            best_q     <= MAX_C;
            new_best_q <= 1'b0;
            no_resp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reaction_q <= reaction_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            no_resp_q  <= no_resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (button_press) state_d = S_PREP;
            S_PREP: begin
                // A press coincident with the timeout is still a false start.
                if (button_press)  state_d = S_FALSE;
                else if (timeout)  state_d = S_TEST;
            end
            S_TEST: begin
                if (button_press)        state_d = S_RESULT;
                else if (cnt_q == MAX_C) state_d = S_RESULT;
            end
            S_RESULT: if (button_press) state_d = S_IDLE;
            S_FALSE: begin
                if (rising_edge_1khz && cnt_q == HOLD_C - 14'd1) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        reaction_d = reaction_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        no_resp_d  = no_resp_q;
        case (state_q)
            S_IDLE: begin
                if (clear_best) best_d = MAX_C;
                if (button_press) begin
                    new_best_d = 1'b0;
                    no_resp_d  = 1'b0;
                end
            end
            S_PREP: begin
                if (button_press || timeout) cnt_d = '0;
            end
            S_TEST: begin
                // The counter saturates at MAX_C; a press in that cycle is still a valid result.
                if (button_press) begin
                    reaction_d = cnt_q;
                    no_resp_d  = 1'b0;
                    if (cnt_q < best_q) begin
                        best_d     = cnt_q;
                        new_best_d = 1'b1;
                    end else begin
                        new_best_d = 1'b0;
                    end
                end else if (cnt_q == MAX_C) begin
                    reaction_d = MAX_C;
                    no_resp_d  = 1'b1;
                    new_best_d = 1'b0;
                end else if (rising_edge_1khz) begin
                    cnt_d = cnt_q + 14'd1;
                end
            end
            S_FALSE: begin
                if (rising_edge_1khz) cnt_d = cnt_q + 14'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        go_led = (state_q == S_TEST);
    end

    assign current_state = state_q;
    assign reaction_ms   = reaction_q;
    assign best_ms       = best_q;
    assign new_best      = new_best_q;
    assign no_response   = no_resp_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Bench for reaction_sequencer: vector table, directed corner sequences and randomized rounds
// checked against a round-level model (tick counting and running minimum).
module tb_reaction_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        press;
    logic        clr;
    logic        tmo;
    logic [2:0]  current_state;
    logic [13:0] reaction_ms;
    logic [13:0] best_ms;
    logic        new_best;
    logic        no_response;
    logic        go_led;

    reaction_sequencer dut (
        .clock            (clock),
        .reset            (reset),
        .rising_edge_1khz (tick),
        .button_press     (press),
        .clear_best       (clr),
        .timeout          (tmo),
        .current_state    (current_state),
        .reaction_ms      (reaction_ms),
        .best_ms          (best_ms),
        .new_best         (new_best),
        .no_response      (no_response),
        .go_led           (go_led)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int best_m = 9999;
    int last_r = 0;

    typedef struct {
        logic       p;
        logic       t;
        logic       to;
        logic       c;
        logic [2:0] st;
        logic       go;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic t, input logic to, input logic c);
        press = p;
        tick  = t;
        tmo   = to;
        clr   = c;
        @(posedge clock);
        #1;
        press = 1'b0;
        tick  = 1'b0;
        tmo   = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        best_m = 9999;
        last_r = 0;
    endtask

    // Full round: start, go, count `ticks` tick cycles, press.
    task automatic play_round(input int ticks, input bit gaps, input string tag);
        int  cnt;
        bit  nb;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_prep"}, 32'(current_state), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk({tag, "_test"}, 32'(current_state), 2);
        chk({tag, "_go"}, 32'(go_led), 1);
        cnt = 0;
        while (cnt < ticks) begin
            logic t;
            t = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1'b0, t, 1'b0, 1'b0);
            if (t) cnt++;
        end
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        nb = (ticks < best_m);
        if (nb) best_m = ticks;
        last_r = ticks;
        chk({tag, "_result"}, 32'(current_state), 3);
        chk({tag, "_react"}, 32'(reaction_ms), ticks);
        chk({tag, "_best"}, 32'(best_ms), best_m);
        chk({tag, "_newbest"}, 32'(new_best), 32'(nb));
        chk({tag, "_noresp"}, 32'(no_response), 0);
        chk({tag, "_go_off"}, 32'(go_led), 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk({tag, "_clr_ignored"}, 32'(best_ms), best_m);
        chk({tag, "_hold"}, 32'(new_best), 32'(nb));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_idle"}, 32'(current_state), 0);
    endtask

    task automatic false_start(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_prep"}, 32'(current_state), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk({tag, "_false"}, 32'(current_state), 4);
        for (int i = 0; i < 1999; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        chk({tag, "_hold1999"}, 32'(current_state), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk({tag, "_idle2000"}, 32'(current_state), 0);
        chk({tag, "_best"}, 32'(best_ms), best_m);
        chk({tag, "_react"}, 32'(reaction_ms), last_r);
    endtask

    initial begin
        reset = 1'b1;
        press = 1'b0;
        tick  = 1'b0;
        clr   = 1'b0;
        tmo   = 1'b0;
        #2;
        chk("rst_state", 32'(current_state), 0);
        chk("rst_react", 32'(reaction_ms), 0);
        chk("rst_best", 32'(best_ms), 9999);
        chk("rst_newbest", 32'(new_best), 0);
        chk("rst_noresp", 32'(no_response), 0);
        chk("rst_go", 32'(go_led), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].p, tbl[i].t, tbl[i].to, tbl[i].c);
            chk($sformatf("vec%0d_state", i), 32'(current_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_go", i), 32'(go_led), 32'(tbl[i].go));
        end
        best_m = 1;
        last_r = 1;
        chk("vec_react", 32'(reaction_ms), 1);
        chk("vec_best", 32'(best_ms), 1);
        for (int i = 0; i < 1998; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("vec_hold", 32'(current_state), 4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("vec_hold_done", 32'(current_state), 0);

        // PREP without timeout waits forever.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5000; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("prep_wait_state", 32'(current_state), 1);
        chk("prep_wait_go", 32'(go_led), 0);

        do_reset();
        play_round(250, 1'b0, "r250");
        chk("r250_best_abs", 32'(best_ms), 250);
        play_round(300, 1'b0, "r300");
        chk("r300_best_abs", 32'(best_ms), 250);
        play_round(250, 1'b0, "r250b");
        chk("r250b_newbest_abs", 32'(new_best), 0);

        false_start("fs");

        // No response: saturate at 9999.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9999; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("nr_still_test", 32'(current_state), 2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        last_r = 9999;
        chk("nr_state", 32'(current_state), 3);
        chk("nr_react", 32'(reaction_ms), 9999);
        chk("nr_flag", 32'(no_response), 1);
        chk("nr_newbest", 32'(new_best), 0);
        chk("nr_best", 32'(best_ms), best_m);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("nr_hold_react", 32'(reaction_ms), 9999);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("nr_idle", 32'(current_state), 0);

        // Press in the cycle the counter sits at its limit is a valid result.
        play_round(9999, 1'b0, "pmax");

        for (int r = 0; r < 25; r++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0 && r < 12) begin
                false_start($sformatf("rfs%0d", r));
            end else if (kind == 1) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                best_m = 9999;
                chk($sformatf("rclr%0d", r), 32'(best_ms), 9999);
            end else begin
                play_round($urandom_range(0, 300), 1'b1, $sformatf("rnd%0d", r));
            end
        end

        // Reset mid-TEST takes effect without a clock edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(current_state), 0);
        chk("mid_rst_best", 32'(best_ms), 9999);
        chk("mid_rst_react", 32'(reaction_ms), 0);
        chk("mid_rst_go", 32'(go_led), 0);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        best_m = 9999;
        last_r = 0;

        play_round(100, 1'b0, "r100");
        step(1'b1, 1'b0, 1'b0, 1'b1);
        best_m = 9999;
        chk("clr_press_state", 32'(current_state), 1);
        chk("clr_press_best", 32'(best_ms), 9999);
        chk("clr_press_newbest", 32'(new_best), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
